ahb_apb_bridge_slave: RTL and testbench
=======================================

# ahb_apb_bridge_slave

AHB-Lite slave endpoint of the AHB-to-APB bridge: it is the responder for the transfers the AHB master issues. It accepts AHB address and data phases, decodes the target APB peripheral, and runs each transfer as one APB SETUP/ACCESS sequence. It stalls the AHB side with `hreadyout` until the APB access completes, and returns read data and the response on the AHB bus.

## Interface
- `BASE_ADDR`, 32'h8000_0000: start of the bridge address window.
- `NSLV`, 3: number of APB peripherals; one `psel` bit each.
- `REGION_BITS`, 26: log2 of region size per peripheral (64 MB). Default window is 0x8000_0000–0x8BFF_FFFF.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `hwrite` in 1: 1 = write, 0 = read.
- `htrans` in 2: IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
- `hsize` in 3: transfer size.
- `hburst` in 3: burst type. Not used for control.
- `hreadyin` in 1: bus-level HREADY.
- `haddr` in 32: address.
- `hwdata` in 32: write data, valid in the data phase.
- `hrdata` out 32: read data.
- `hreadyout` out 1: slave ready.
- `hresp` out 2: 00 OKAY, 01 ERROR.
- `paddr` out 32, `pwdata` out 32, `pwrite` out 1: APB address, write data and direction.
- `psel` out NSLV: one-hot peripheral select.
- `penable` out 1: APB enable.
- `prdata` in 32: APB read data.
- `pready` in 1: APB ready.

## Operation
- A transfer is valid when `hreadyin` = 1, `htrans[1]` = 1 and `hreadyout` = 1. Only valid transfers are sampled.
- IDLE and BUSY transfers get a zero-wait OKAY response. The FSM does not move.
- Legal transfer: `haddr` is inside the window and `hsize` ≤ 3'b010.
  - At the sampling edge, latch `haddr`, `hwrite` and the decoded select.
  - Select index = (`haddr` − `BASE_ADDR`) >> `REGION_BITS`.
- Illegal transfer (outside the window, or `hsize` > 010): two-cycle ERROR response, no APB activity.
- SEQ beats are handled exactly like NONSEQ. Each burst beat is a separate APB access. The address is taken from `haddr` each beat.
- FSM states:
  - IDLE: `hreadyout` = 1. A legal read goes to SETUP. A legal write goes to WDATA. An illegal transfer goes to ERR1.
  - WDATA: `hreadyout` = 0. `hwdata` is latched into `pwdata`. Goes to SETUP.
  - SETUP: `psel[idx]` = 1, `penable` = 0. Goes to ACCESS.
  - ACCESS: `psel[idx]` = 1, `penable` = 1. Holds while `pready` = 0. When `pready` = 1, goes to IDLE; on a read, `prdata` is registered into `hrdata` at that edge.
  - ERR1: `hresp` = 01, `hreadyout` = 0. Goes to ERR2.
  - ERR2: `hresp` = 01, `hreadyout` = 1. Goes to IDLE.
- `paddr`, `pwrite` and `pwdata` stay stable from SETUP through the final ACCESS cycle.
- `hrdata` holds its last read value until the next read completes. Writes do not change it.
- `hreadyout` and `hresp` are decoded from the registered state only, not combinationally from AHB inputs.

## Timing
- Reset values: state IDLE, `hreadyout` = 1, `hresp` = 00, `hrdata` = 0, `psel` = 0, `penable` = 0, `pwrite` = 0, `paddr` = 0, `pwdata` = 0.
- `rst` asserted in any state, including mid-ACCESS: the next edge forces the reset values. The in-flight transfer is dropped with no response.
- Read with address phase in cycle N and `pready` = 1 immediately:
  - N+1 SETUP.
  - N+2 ACCESS.
  - N+3 `hreadyout` = 1 and `hrdata` valid.
  - Latency is 3 cycles, plus 1 per `pready` = 0 wait cycle.
- Write with address phase in cycle N:
  - N+1 WDATA (captures `hwdata`).
  - N+2 SETUP.
  - N+3 ACCESS.
  - N+4 `hreadyout` = 1.
- Back-to-back: the IDLE cycle that completes a data phase also samples the next address phase. There is no dead cycle between transfers.
- `htrans` changing while `hreadyout` = 0 is ignored. The master holds the pipeline per AHB-Lite.
- Address exactly `BASE_ADDR` + NSLV·2^REGION_BITS is out of range. `BASE_ADDR` − 1 is out of range.

## Test plan
- Single read 0x8000_00A2, hsize 000, `prdata` = 32'h1234_5678, `pready` = 1:
  - `psel` = 001 and `paddr` = 0x8000_00A2 in SETUP/ACCESS.
  - `hrdata` = 32'h1234_5678 with `hreadyout` = 1 at N+3.
  - `hresp` = 00.
- Single write 0x8000_0001, hwdata 32'hA300_1111 in data phase:
  - `pwrite` = 1 and `pwdata` = 32'hA300_1111 at N+2..N+3.
  - `hreadyout` = 1 at N+4.
- 4-beat INCR read from 0x8000_00C0, SEQ beats at C4, C8, CC:
  - Four SETUP/ACCESS pairs with `paddr` C0, C4, C8, CC.
  - Each beat completes OKAY.
  - No gap cycles between beats.
- `pready` held 0 for 3 cycles in ACCESS:
  - `penable` = 1 for 4 cycles.
  - `paddr`/`pwdata` stable throughout.
  - `hreadyout` low until the cycle after `pready` = 1.
- Read 0x8C00_0000 (out of range), then hsize 011 to 0x8000_0000:
  - Each gives `hresp` = 01 for 2 cycles with `hreadyout` 0 then 1.
  - `psel` stays 0.
- `rst` = 1 during ACCESS of a write:
  - Next edge shows all reset values.
  - A following read to 0x8400_0000 selects `psel` = 010 normally.

Source files
------------

// File: rtl/ahb_apb_bridge_slave.sv
// AHB-Lite slave side of the AHB-to-APB bridge.
// Runs each legal AHB transfer as one APB SETUP/ACCESS pair.
//
// Ports:
//   clk, rst        : clock, sync active-high reset
//   hwrite..hwdata  : AHB-Lite address/data phase inputs
//   hrdata, hreadyout, hresp : AHB-Lite slave response
//   paddr, pwdata, pwrite, psel, penable : APB request
//   prdata, pready  : APB completion
module ahb_apb_bridge_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          NSLV        = 3,
  parameter int          REGION_BITS = 26
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hwrite,
  input  logic [1:0]      htrans,
  input  logic [2:0]      hsize,
  input  logic [2:0]      hburst,
  input  logic            hreadyin,
  input  logic [31:0]     haddr,
  input  logic [31:0]     hwdata,
  output logic [31:0]     hrdata,
  output logic            hreadyout,
  output logic [1:0]      hresp,
  output logic [31:0]     paddr,
  output logic [31:0]     pwdata,
  output logic            pwrite,
  output logic [NSLV-1:0] psel,
  output logic            penable,
  input  logic [31:0]     prdata,
  input  logic            pready
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WDATA  = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_ERR1   = 3'd4;
  localparam logic [2:0] S_ERR2   = 3'd5;

  // Window size; 33 bits so a window reaching 4 GB still compares.
  localparam logic [32:0] SPAN =
    33'(NSLV) << REGION_BITS;

  logic [2:0]      state;
  logic [2:0]      state_d;
  logic [NSLV-1:0] sel_q;
  logic [NSLV-1:0] sel_d;
  logic [31:0]     off;
  logic [31:0]     idx;
  logic            in_win;
  logic            legal;
  logic            valid;
  logic            unused;

  // Burst type and SEQ/NONSEQ distinction do not steer the FSM.
  assign unused = ^{hburst, htrans[0]};

  assign off    = haddr - BASE_ADDR;
  assign idx    = off >> REGION_BITS;
  assign in_win = (haddr >= BASE_ADDR) &&
                  ({1'b0, off} < SPAN);
  assign legal  = in_win && (hsize <= 3'b010);
  assign valid  = hreadyin && htrans[1] && hreadyout;

  always_comb begin
    sel_d = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx == 32'(i)) sel_d[i] = 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (valid) begin
          if (!legal)      state_d = S_ERR1;
          else if (hwrite) state_d = S_WDATA;
          else             state_d = S_SETUP;
        end
      end
      S_WDATA:  state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (pready) state_d = S_IDLE;
      S_ERR1:   state_d = S_ERR2;
      S_ERR2:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      sel_q  <= '0;
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
      hrdata <= '0;
    end else begin
      state <= state_d;
      // APB request fields only move on a new legal
      // address phase, so they hold through ACCESS.
      if (state == S_IDLE && valid && legal) begin
        paddr  <= haddr;
        pwrite <= hwrite;
        sel_q  <= sel_d;
      end
      if (state == S_WDATA) pwdata <= hwdata;
      if (state == S_ACCESS && pready && !pwrite)
        hrdata <= prdata;
    end
  end

  // Responses come from the registered state only.
  assign hreadyout = (state == S_IDLE) ||
                     (state == S_ERR2);
  assign hresp     = (state == S_ERR1 ||
                      state == S_ERR2) ? 2'b01 : 2'b00;
  assign psel      = (state == S_SETUP ||
                      state == S_ACCESS) ? sel_q : '0;
  assign penable   = (state == S_ACCESS);

endmodule

// File: tb/tb_ahb_apb_bridge_slave.sv
// Directed bench for ahb_apb_bridge_slave.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_ahb_apb_bridge_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hreadyin;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic [2:0]  psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ahb_apb_bridge_slave dut (
    .clk       (clk),
    .rst       (rst),
    .hwrite    (hwrite),
    .htrans    (htrans),
    .hsize     (hsize),
    .hburst    (hburst),
    .hreadyin  (hreadyin),
    .haddr     (haddr),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pwrite    (pwrite),
    .psel      (psel),
    .penable   (penable),
    .prdata    (prdata),
    .pready    (pready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    htrans   = 2'b00;
    hwrite   = 1'b0;
    hsize    = 3'b000;
    haddr    = 32'h0;
    hreadyin = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_bus();
    hburst = 3'b000; hwdata = 32'h0;
    prdata = 32'h0; pready = 1'b1;
    tick(); tick();
    @(negedge clk);
    total++;
    if ({hreadyout, hresp, psel, penable, pwrite}
        !== 8'b1_00_000_0_0)
      $display("FAIL reset_ctl got %b want 10000000",
        {hreadyout, hresp, psel, penable, pwrite});
    else passed++;
    total++;
    if ({paddr, pwdata, hrdata} !== 96'h0)
      $display("FAIL reset_data got %h want 0",
        {paddr, pwdata, hrdata});
    else passed++;
    tick(); rst = 1'b0;
  endtask

  task automatic test_read();
    tick();
    htrans = 2'b10; haddr = 32'h8000_00A2;
    hwrite = 1'b0; hsize = 3'b000;
    prdata = 32'h1234_5678; pready = 1'b1;
    tick(); idle_bus();
    @(negedge clk);
    total++;
    if ({psel, penable, hreadyout, paddr}
        !== {3'b001, 1'b0, 1'b0, 32'h8000_00A2})
      $display("FAIL rd_setup got %b %h want 001 0 0 800000a2",
        {psel, penable, hreadyout}, paddr);
    else passed++;
    tick();
    @(negedge clk);
    total++;
    if ({psel, penable, hreadyout, paddr}
        !== {3'b001, 1'b1, 1'b0, 32'h8000_00A2})
      $display("FAIL rd_access got %b %h want 001 1 0 800000a2",
        {psel, penable, hreadyout}, paddr);
    else passed++;
    tick();
    @(negedge clk);
    total++;
    if ({hreadyout, hresp, psel, hrdata}
        !== {1'b1, 2'b00, 3'b000, 32'h1234_5678})
      $display("FAIL rd_done got %b %h want 100000 12345678",
        {hreadyout, hresp, psel}, hrdata);
    else passed++;
  endtask

  task automatic test_write();
    tick();
    htrans = 2'b10; haddr = 32'h8000_0001;
    hwrite = 1'b1; hsize = 3'b000;
    prdata = 32'hDEAD_BEEF;
    tick(); idle_bus(); hwdata = 32'hA300_1111;
    @(negedge clk);
    total++;
    if ({hreadyout, psel, penable, pwrite}
        !== 6'b0_000_0_1)
      $display("FAIL wr_wdata got %b want 000001",
        {hreadyout, psel, penable, pwrite});
    else passed++;
    tick(); hwdata = 32'h0;
    @(negedge clk);
    total++;
    if ({psel, penable, pwrite, hreadyout, pwdata, paddr}
        !== {6'b001_0_1_0, 32'hA300_1111, 32'h8000_0001})
      $display("FAIL wr_setup got %b %h %h",
        {psel, penable, pwrite, hreadyout}, pwdata, paddr);
    else passed++;
    tick();
    @(negedge clk);
    total++;
    if ({psel, penable, pwrite, hreadyout, pwdata}
        !== {6'b001_1_1_0, 32'hA300_1111})
      $display("FAIL wr_access got %b %h want 001110 a3001111",
        {psel, penable, pwrite, hreadyout}, pwdata);
    else passed++;
    tick();
    @(negedge clk);
    total++;
    if ({hreadyout, hresp, hrdata}
        !== {3'b1_00, 32'h1234_5678})
      $display("FAIL wr_done got %b %h want 100 12345678",
        {hreadyout, hresp}, hrdata);
    else passed++;
  endtask

  task automatic test_burst();
    logic [31:0] a;
    for (int k = 0; k < 4; k++) begin
      a = 32'h8000_00C0 + 32'(4 * k);
      tick();
      htrans = (k == 0) ? 2'b10 : 2'b11;
      haddr = a; hwrite = 1'b0; hsize = 3'b010;
      pready = 1'b1;
      @(negedge clk);
      total++;
      if ({hreadyout, hresp} !== 3'b1_00)
        $display("FAIL burst_ready%0d got %b want 100",
          k, {hreadyout, hresp});
      else passed++;
      if (k > 0) begin
        total++;
        if (hrdata !== 32'hB000_0000 + 32'(k - 1))
          $display("FAIL burst_data%0d got %h want %h",
            k - 1, hrdata, 32'hB000_0000 + 32'(k - 1));
        else passed++;
      end
      // Next beat is presented early; it must be ignored
      // until the bridge returns to ready.
      tick();
      htrans = (k < 3) ? 2'b11 : 2'b00;
      haddr = a + 32'h4;
      @(negedge clk);
      total++;
      if ({psel, penable, paddr} !== {4'b001_0, a})
        $display("FAIL burst_setup%0d got %b %h want 0010 %h",
          k, {psel, penable}, paddr, a);
      else passed++;
      tick();
      prdata = 32'hB000_0000 + 32'(k);
      @(negedge clk);
      total++;
      if ({psel, penable, paddr} !== {4'b001_1, a})
        $display("FAIL burst_access%0d got %b %h want 0011 %h",
          k, {psel, penable}, paddr, a);
      else passed++;
    end
    tick(); idle_bus();
    @(negedge clk);
    total++;
    if ({hreadyout, hresp, hrdata}
        !== {3'b1_00, 32'hB000_0003})
      $display("FAIL burst_last got %b %h want 100 b0000003",
        {hreadyout, hresp}, hrdata);
    else passed++;
  endtask

  task automatic test_wait();
    tick();
    htrans = 2'b10; haddr = 32'h8400_0010;
    hwrite = 1'b1; hsize = 3'b010; pready = 1'b1;
    tick(); idle_bus();
    hwdata = 32'h5A5A_5A5A; pready = 1'b0;
    tick(); hwdata = 32'h0;
    @(negedge clk);
    total++;
    if ({psel, penable, hreadyout} !== 5'b010_0_0)
      $display("FAIL wait_setup got %b want 01000",
        {psel, penable, hreadyout});
    else passed++;
    for (int j = 0; j < 4; j++) begin
      tick();
      pready = (j == 3);
      @(negedge clk);
      total++;
      if ({psel, penable, hreadyout, paddr, pwdata}
          !== {5'b010_1_0, 32'h8400_0010, 32'h5A5A_5A5A})
        $display("FAIL wait_access%0d got %b %h %h",
          j, {psel, penable, hreadyout}, paddr, pwdata);
      else passed++;
    end
    tick(); pready = 1'b1;
    @(negedge clk);
    total++;
    if ({hreadyout, hresp, psel, penable}
        !== 7'b1_00_000_0)
      $display("FAIL wait_done got %b want 1000000",
        {hreadyout, hresp, psel, penable});
    else passed++;
  endtask

  task automatic test_error();
    logic [31:0] ea [3];
    logic [2:0]  es [3];
    ea = '{32'h8C00_0000, 32'h8000_0000, 32'h7FFF_FFFF};
    es = '{3'b000, 3'b011, 3'b000};
    for (int e = 0; e < 3; e++) begin
      tick();
      htrans = 2'b10; haddr = ea[e];
      hwrite = 1'b0; hsize = es[e];
      tick(); idle_bus();
      @(negedge clk);
      total++;
      if ({hreadyout, hresp, psel, penable}
          !== 7'b0_01_000_0)
        $display("FAIL err1_%0d got %b want 0010000",
          e, {hreadyout, hresp, psel, penable});
      else passed++;
      tick();
      @(negedge clk);
      total++;
      if ({hreadyout, hresp, psel, penable}
          !== 7'b1_01_000_0)
        $display("FAIL err2_%0d got %b want 1010000",
          e, {hreadyout, hresp, psel, penable});
      else passed++;
      tick();
      @(negedge clk);
      total++;
      if ({hreadyout, hresp, psel} !== 6'b1_00_000)
        $display("FAIL err_end%0d got %b want 100000",
          e, {hreadyout, hresp, psel});
      else passed++;
    end
    // Last word of the window is still legal.
    tick();
    htrans = 2'b10; haddr = 32'h8BFF_FFFC;
    hsize = 3'b010; prdata = 32'h0BAD_CAFE;
    tick(); idle_bus();
    @(negedge clk);
    total++;
    if ({psel, hresp, hreadyout} !== 6'b100_00_0)
      $display("FAIL top_setup got %b want 100000",
        {psel, hresp, hreadyout});
    else passed++;
    tick(); tick();
    @(negedge clk);
    total++;
    if ({hreadyout, hrdata} !== {1'b1, 32'h0BAD_CAFE})
      $display("FAIL top_done got %b %h want 1 0badcafe",
        hreadyout, hrdata);
    else passed++;
  endtask

  task automatic test_idle_busy();
    tick();
    htrans = 2'b01; haddr = 32'h8000_0000;
    tick();
    htrans = 2'b10; hreadyin = 1'b0;
    @(negedge clk);
    total++;
    if ({hreadyout, hresp, psel, penable}
        !== 7'b1_00_000_0)
      $display("FAIL busy got %b want 1000000",
        {hreadyout, hresp, psel, penable});
    else passed++;
    tick(); idle_bus();
    @(negedge clk);
    total++;
    if ({hreadyout, hresp, psel, penable}
        !== 7'b1_00_000_0)
      $display("FAIL noready got %b want 1000000",
        {hreadyout, hresp, psel, penable});
    else passed++;
  endtask

  task automatic test_reset_midflight();
    tick();
    htrans = 2'b10; haddr = 32'h8000_0004;
    hwrite = 1'b1; hsize = 3'b010; pready = 1'b0;
    tick(); idle_bus(); hwdata = 32'hCAFE_F00D;
    tick();
    tick();
    @(negedge clk);
    total++;
    if ({penable, pwrite, psel} !== 5'b1_1_001)
      $display("FAIL mid_access got %b want 11001",
        {penable, pwrite, psel});
    else passed++;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; pready = 1'b1;
    htrans = 2'b10; haddr = 32'h8400_0000;
    hwrite = 1'b0; hsize = 3'b010;
    prdata = 32'h0000_0077;
    @(negedge clk);
    total++;
    if ({hreadyout, hresp, psel, penable, pwrite}
        !== 8'b1_00_000_0_0)
      $display("FAIL mid_rst_ctl got %b want 10000000",
        {hreadyout, hresp, psel, penable, pwrite});
    else passed++;
    total++;
    if ({paddr, pwdata, hrdata} !== 96'h0)
      $display("FAIL mid_rst_data got %h want 0",
        {paddr, pwdata, hrdata});
    else passed++;
    tick(); idle_bus();
    @(negedge clk);
    total++;
    if ({psel, penable, paddr}
        !== {4'b010_0, 32'h8400_0000})
      $display("FAIL post_setup got %b %h want 0100 84000000",
        {psel, penable}, paddr);
    else passed++;
    tick();
    @(negedge clk);
    total++;
    if ({psel, penable} !== 4'b010_1)
      $display("FAIL post_access got %b want 0101",
        {psel, penable});
    else passed++;
    tick();
    @(negedge clk);
    total++;
    if ({hreadyout, hresp, hrdata}
        !== {3'b1_00, 32'h0000_0077})
      $display("FAIL post_done got %b %h want 100 00000077",
        {hreadyout, hresp}, hrdata);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_burst();
    test_wait();
    test_error();
    test_idle_busy();
    test_reset_midflight();
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
